// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parametrised UART receiver with a show-ahead receive FIFO.
//
// The receiver synchronises rx and rejects false starts. It supports 5..8 data bits
// sent LSB first, an optional even or odd parity bit, and one or two stop bits.
// A good frame is pushed into a show-ahead FIFO. Framing, parity and overrun errors
// are sticky flags, and irq combines them with a FIFO level threshold.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   clk_div       clk cycles per bit (values below 4 behave as 4)
//   parity_en     parity bit follows the data bits
//   parity_odd    odd parity when set, even otherwise
//   two_stop      two stop bits are checked
//   rx            asynchronous serial input, idle high
//   rd_en         pop the FIFO head (ignored when empty)
//   irq_thresh    level interrupt threshold, 0 disables the level term
//   err_clr       clears all sticky error flags
//   rx_data       FIFO head, valid while rx_valid
//   rx_valid      FIFO not empty
//   level         FIFO occupancy 0..FIFO_DEPTH
//   busy          a frame is in progress
//   frame_err     sticky: a stop bit was sampled low
//   parity_err    sticky: parity mismatch on an otherwise good frame
//   overrun       sticky: a good frame arrived while the FIFO was full
//   irq           level threshold reached or any sticky error set
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          clk_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    input  logic                 rx,
    input  logic                 rd_en,
    input  logic [LVL_W-1:0]     irq_thresh,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic [LVL_W-1:0]     level,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 irq
);

    localparam int AW = LVL_W - 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BREAK
    } state_t;

    state_t               state;
    logic                 rx_meta, rxs;
    logic [31:0]          cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LVL_W-1:0]     count;

    logic [31:0] div_eff;
    logic        bit_tick, half_tick, last_stop, stop_sample;
    logic        frame_set, parity_set, push_req, full, pop, push, overrun_set;

    // Two-flop synchroniser. It resets to the idle level so that leaving reset
    // never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // NOTE: every signal assigned in this block gets a default value first. Without
    // the defaults, a path that leaves a signal unassigned would infer a latch.
    always_comb begin
        div_eff     = (clk_div < 32'd4) ? 32'd4 : clk_div;
        bit_tick    = (cnt == div_eff - 32'd1);
        half_tick   = (cnt == (div_eff >> 1) - 32'd1);
        last_stop   = (state == S_STOP2) || ((state == S_STOP1) && !two_stop);
        stop_sample = bit_tick && ((state == S_STOP1) || (state == S_STOP2));
        frame_set   = stop_sample && !rxs;
        parity_set  = stop_sample && rxs && last_stop && perr;
        push_req    = stop_sample && rxs && last_stop && !perr;
        full        = (count == LVL_W'(FIFO_DEPTH));
        pop         = rd_en && (count != '0);
        // A pop in the same cycle makes room, so a full FIFO still accepts the word.
        push        = push_req && (!full || pop);
        overrun_set = push_req && full && !pop;
    end

    // NOTE: sequential state uses only non-blocking assignments. All registers then
    // update together at the clock edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            perr    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state   <= S_START;
                        bit_cnt <= '0;
                        perr    <= 1'b0;
                    end
                end
                S_START: begin
                    if (half_tick) begin
                        cnt   <= '0;
                        // A start bit that is gone by mid-bit was a glitch.
                        state <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == BW'(DATA_BITS - 1))
                            state <= parity_en ? S_PARITY : S_STOP1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_PARITY: begin
                    if (bit_tick) begin
                        cnt   <= '0;
                        perr  <= (rxs != ((^shreg) ^ parity_odd));
                        state <= S_STOP1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_STOP1: begin
                    if (bit_tick) begin
                        cnt <= '0;
                        if (!rxs)         state <= S_BREAK;
                        else if (two_stop) state <= S_STOP2;
                        else              state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_STOP2: begin
                    if (bit_tick) begin
                        cnt   <= '0;
                        state <= rxs ? S_IDLE : S_BREAK;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_BREAK: begin
                    // Stay here while the line is low so a long break cannot
                    // start a new frame.
                    cnt <= '0;
                    if (rxs) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the storage array has no reset. Only the pointers and the count define
    // what is valid, and rx_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flags. A new error wins over err_clr in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= frame_set   | (frame_err  & ~err_clr);
            parity_err <= parity_set  | (parity_err & ~err_clr);
            overrun    <= overrun_set | (overrun    & ~err_clr);
        end
    end

    assign rx_valid = (count != '0);
    assign rx_data  = rx_valid ? mem[rd_ptr] : '0;
    assign level    = count;
    assign busy     = (state != S_IDLE);
    assign irq      = ((irq_thresh != '0) && (count >= irq_thresh))
                      | frame_err | parity_err | overrun;

endmodule
